// File: rtl/timer_sink_pkg.sv
// Shared parameters and state encodings for the timer sink and its BCD converter.
package timer_sink_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DIGITS_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_DONE  = 2'd2
    } cv_state_t;

    // Double-dabble digit correction applied before every shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/timer_sink_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock.
// load is accepted in CV_IDLE and CV_DONE; state is exposed for observation.
module bin2bcd_seq
    import timer_sink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  done,
    output cv_state_t             state
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    cv_state_t              state_q;
    cv_state_t              state_d;
    logic [DATA_W-1:0]      shift_reg;
    logic [4*DIGITS-1:0]    bcd_acc;
    logic [4*DIGITS-1:0]    bcd_adj;
    logic [CNT_W-1:0]       bit_cnt;

    assign state = state_q;

    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = dd_adj(bcd_acc[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CV_IDLE:  if (load) state_d = CV_SHIFT;
            CV_SHIFT: if (bit_cnt == CNT_LAST) state_d = CV_DONE;
            CV_DONE:  state_d = load ? CV_SHIFT : CV_IDLE;
            default:  state_d = CV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bcd_acc   <= '0;
            bit_cnt   <= '0;
            bcd_out   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                CV_IDLE: begin
                    if (load) begin
                        shift_reg <= data_in;
                        bcd_acc   <= '0;
                        bit_cnt   <= CNT_INIT;
                    end
                end
                CV_SHIFT: begin
                    // Top bit of the corrected accumulator is always zero when 10^DIGITS covers the range.
                    bcd_acc   <= {bcd_adj[4*DIGITS-2:0], shift_reg[DATA_W-1]};
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - CNT_LAST;
                end
                CV_DONE: begin
                    bcd_out <= bcd_acc;
                    done    <= 1'b1;
                    if (load) begin
                        shift_reg <= data_in;
                        bcd_acc   <= '0;
                        bit_cnt   <= CNT_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/timer_sink.sv
// Timer interface consumer: start/stop edge detect, run control, sample capture
// with a one-deep pending slot, and BCD conversion for the display path.
module timer_sink
    import timer_sink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  t_valid,
    input  logic [DATA_W-1:0]     t_out,
    output logic                  t_en,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overrun
);

    logic              start_prev;
    logic              stop_prev;
    logic              start_edge;
    logic              stop_edge;
    ctrl_state_t       ctrl_q;
    ctrl_state_t       ctrl_d;
    logic              go_run;

    cv_state_t         cv_state;
    logic              cv_idle;
    logic              cv_done;
    logic              pending_full;
    logic [DATA_W-1:0] pending_data;
    logic              drain;
    logic              direct;
    logic              conv_load;
    logic [DATA_W-1:0] conv_data;
    logic              overrun_set;

    assign start_edge = start & ~start_prev;
    assign stop_edge  = stop & ~stop_prev;

    always_comb begin
        ctrl_d = ctrl_q;
        if (stop_edge) begin
            ctrl_d = IDLE;
        end else if (start_edge && ctrl_q == IDLE) begin
            ctrl_d = RUN;
        end
    end

    assign go_run = (ctrl_q == IDLE) && (ctrl_d == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            ctrl_q     <= IDLE;
            t_en       <= 1'b0;
        end else begin
            start_prev <= start;
            stop_prev  <= stop;
            ctrl_q     <= ctrl_d;
            t_en       <= (ctrl_d == RUN);
        end
    end

    assign cv_idle = (cv_state == CV_IDLE);
    assign cv_done = (cv_state == CV_DONE);

    // A pending sample is handed over whenever the converter can accept a load.
    assign drain       = pending_full & (cv_idle | cv_done);
    assign direct      = t_valid & cv_idle & ~pending_full;
    assign conv_load   = drain | direct;
    assign conv_data   = drain ? pending_data : t_out;
    assign overrun_set = t_valid & pending_full & ~drain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_full <= 1'b0;
            pending_data <= '0;
            overrun      <= 1'b0;
        end else begin
            if (t_valid && !direct) begin
                pending_full <= 1'b1;
                pending_data <= t_out;
            end else if (drain) begin
                pending_full <= 1'b0;
            end
            if (go_run) overrun <= 1'b0;
            if (overrun_set) overrun <= 1'b1;
        end
    end

    assign busy = ~cv_idle | pending_full;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .load    (conv_load),
        .data_in (conv_data),
        .bcd_out (bcd_out),
        .done    (bcd_valid),
        .state   (cv_state)
    );

endmodule

// File: tb/tb_timer_sink.sv
// Directed bench for timer_sink: event-level reference model checked every cycle,
// plus literal expectations on conversion results, latency and control behaviour.
module tb_timer_sink;

    localparam int DATA_W = 16;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;
    localparam int LAT    = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              t_valid = 1'b0;
    logic [DATA_W-1:0] t_out = '0;
    logic              t_en;
    logic [BW-1:0]     bcd_out;
    logic              bcd_valid;
    logic              busy;
    logic              overrun;

    int n_vec = 0;
    int n_err = 0;

    timer_sink #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .t_valid   (t_valid),
        .t_out     (t_out),
        .t_en      (t_en),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: converter modelled as a deadline per sample,
    // values computed with decimal arithmetic.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    bit        m_sp, m_stp, m_run, m_ovr, m_valid, m_active, m_pf;
    int        m_t, m_done_at, m_cur, m_pv;
    logic [BW-1:0] m_bcd;

    always @(posedge clk or negedge rst) begin
        bit se, ste, was_idle, was_done, drain, pf_old;
        if (!rst) begin
            m_sp = 0; m_stp = 0; m_run = 0; m_ovr = 0; m_valid = 0;
            m_active = 0; m_pf = 0; m_t = 0; m_done_at = 0; m_cur = 0; m_pv = 0;
            m_bcd = '0;
        end else begin
            m_t++;
            se  = start & ~m_sp;
            ste = stop & ~m_stp;
            m_sp  = start;
            m_stp = stop;
            if (ste) m_run = 0;
            else if (se && !m_run) begin
                m_run = 1;
                m_ovr = 0;
            end
            m_valid  = 0;
            was_idle = !m_active;
            was_done = m_active && (m_t == m_done_at);
            pf_old   = m_pf;
            if (was_done) begin
                m_bcd    = to_bcd(m_cur);
                m_valid  = 1;
                m_active = 0;
            end
            drain = pf_old && (was_idle || was_done);
            if (drain) begin
                m_cur     = m_pv;
                m_active  = 1;
                m_done_at = m_t + LAT;
                m_pf      = 0;
            end
            if (t_valid) begin
                if (was_idle && !pf_old) begin
                    m_cur     = int'(t_out);
                    m_active  = 1;
                    m_done_at = m_t + LAT;
                end else begin
                    if (pf_old && !drain) m_ovr = 1;
                    m_pv = int'(t_out);
                    m_pf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        n_vec++;
        if (t_en !== m_run || bcd_out !== m_bcd || bcd_valid !== m_valid ||
            busy !== (m_active || m_pf) || overrun !== m_ovr) begin
            n_err++;
            $display("FAIL cycle_model t=%0t got en=%b bcd=%h v=%b busy=%b ovr=%b want en=%b bcd=%h v=%b busy=%b ovr=%b",
                     $time, t_en, bcd_out, bcd_valid, busy, overrun,
                     m_run, m_bcd, m_valid, (m_active || m_pf), m_ovr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] v);
        t_valid = 1'b1;
        t_out   = v;
        step(1);
        t_valid = 1'b0;
        t_out   = '0;
    endtask

    task automatic wait_bcd(input string name, input logic [BW-1:0] exp, input int exp_lat);
        int k;
        bit seen;
        seen = 0;
        k = 0;
        while (!seen && k < 40) begin
            step(1);
            k++;
            if (bcd_valid) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout got no bcd_valid within 40 cycles want latency %0d", name, exp_lat);
        end else begin
            check({name, "_value"}, 32'(bcd_out), 32'(exp));
            check({name, "_latency"}, 32'(k), 32'(exp_lat));
            step(1);
            check({name, "_pulse_width"}, 32'(bcd_valid), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            start   = 1'($urandom_range(0, 1));
            stop    = 1'($urandom_range(0, 1));
            t_valid = 1'($urandom_range(0, 1));
            t_out   = 16'($urandom_range(0, 65535));
            step(1);
            check("reset_outputs", {t_en, bcd_valid, busy, overrun, 8'd0, 20'(bcd_out)}, 32'd0);
        end
        start = 0; stop = 0; t_valid = 0; t_out = '0;
        rst = 1'b1;
        step(3);
        check("post_reset_t_en", 32'(t_en), 32'd0);

        pulse_start();
        check("start_t_en", 32'(t_en), 32'd1);
        step(1);

        send(16'd12345);
        check("busy_after_load", 32'(busy), 32'd1);
        wait_bcd("conv_12345", 20'h12345, LAT);
        send(16'd0);
        wait_bcd("conv_0", 20'h00000, LAT);
        send(16'hFFFF);
        wait_bcd("conv_65535", 20'h65535, LAT);
        send(16'd9999);
        wait_bcd("conv_9999", 20'h09999, LAT);
        step(2);
        check("bcd_hold", 32'(bcd_out), 32'h09999);

        // Back-to-back: 200 is overwritten by 300.
        send(16'd100);
        step(4);
        send(16'd200);
        step(2);
        send(16'd300);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_bcd("b2b_100", 20'h00100, 9);
        wait_bcd("b2b_300", 20'h00300, LAT - 1);
        check("overrun_sticky", 32'(overrun), 32'd1);
        step(3);
        check("idle_not_busy", 32'(busy), 32'd0);

        pulse_stop();
        check("stop_t_en", 32'(t_en), 32'd0);
        check("bcd_kept_after_stop", 32'(bcd_out), 32'h00300);
        step(1);
        pulse_start();
        check("overrun_cleared", 32'(overrun), 32'd0);
        step(1);
        pulse_stop();
        step(1);

        // Simultaneous edges in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        check("simul_edges_idle", 32'(t_en), 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        step(1);
        pulse_start();
        step(1);
        pulse_start();
        check("start_in_run", 32'(t_en), 32'd1);
        step(1);

        // Trailing sample after stop still converts.
        pulse_stop();
        send(16'd42);
        wait_bcd("after_stop_42", 20'h00042, LAT);

        // Reset in the middle of a conversion.
        send(16'd777);
        step(7);
        rst = 1'b0;
        #1;
        check("midreset_outputs", {t_en, bcd_valid, busy, overrun, 8'd0, 20'(bcd_out)}, 32'd0);
        step(2);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bcd_valid) seen = 1;
        end
        check("midreset_no_valid", 32'(seen), 32'd0);
        check("midreset_bcd_zero", 32'(bcd_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
